clk_prescaler: RTL and testbench
================================

# clk_prescaler

- Programmable prescaler that emits a one-cycle `otick` pulse every D cycles of `iclk`.
- Sits directly upstream of the toggle divider stage and drives that stage's clock/enable input, so the toggle output has period 2·D.
- The divisor is loaded at runtime through a request/acknowledge handshake.
- By default a new divisor takes effect at the next period boundary, so no glitched tick is produced.

## Interface
- `W`, default 16: width of the divisor and of the internal counter.
- `RESET_DIV`, default 2: divisor value after reset. Must be ≥1.
- `iclk`  in  1: sole clock, rising edge.
- `irst_n`  in  1: synchronous, active-low reset, sampled on `iclk` rising edge.
- `ien`  in  1: run enable.
- `idiv`  in  W: new divisor D. Value 0 is treated as 1.
- `iload`  in  1: load request, qualifies `idiv`. Single-cycle or level; each sampled-high cycle is a request.
- `oack`  out  1: one-cycle pulse when the loaded divisor becomes active.
- `otick`  out  1: registered one-cycle tick.
- `obusy`  out  1: a load is pending (state PEND).

## Operation
- Internal registers:
  - `div_r` (W bits): active divisor.
  - `pend_r` (W bits): pending divisor.
  - `cnt` (W bits): down-counter.
- Effective divisor is `max(idiv,1)`, applied at capture.
- Reset (`irst_n`=0 at an edge), all outputs registered:
  - `div_r`=RESET_DIV, `cnt`=RESET_DIV−1, `pend_r`=0, state IDLE.
  - `otick`=0, `oack`=0, `obusy`=0.
  - Reset overrides every other input, including a pending load, which is discarded without `oack`.
- States:
  - IDLE: `cnt` held at `div_r`−1, `otick`=0.
    - `iload`: `div_r`←D, `cnt`←D−1, `oack`=1 next cycle.
    - `ien`=1: →RUN with `cnt`←`div_r`−1, no decrement on this edge.
    - If `iload` and `ien` occur together, the new D is used.
  - RUN, each edge:
    - If `cnt`==0: `otick`←1, `cnt`←`div_r`−1.
    - Otherwise: `cnt`←`cnt`−1, `otick`←0.
    - `iload` → PEND with `pend_r`←D.
  - PEND: counts exactly as RUN, with `obusy`=1.
    - At the edge where `cnt`==0: `otick`←1, `div_r`←`pend_r`, `cnt`←`pend_r`−1, `oack`←1, →RUN. The old period completes, then the new one starts.
    - `iload` in PEND overwrites `pend_r`. Only one `oack` is issued, for the last value.
    - If `iload` arrives on the same edge as the terminal count in PEND, that value is applied and acknowledged.
- `ien`=0 in RUN or PEND: at the next edge go to IDLE, `otick`←0, `cnt`←`div_r`−1.
  - This suppresses any tick due on that edge.
  - A pending divisor is committed to `div_r` with `oack`, without a tick.
- Counter arithmetic is unsigned W-bit. The counter never wraps below 0 because it reloads at 0.

## Timing
- `ien` first sampled high at edge k with divisor D: `otick` is high in the cycle after edge k+D, then every D cycles.
- D=1: `otick` is high continuously from edge k+1.
- `oack` is always exactly one cycle wide and is never asserted twice for one value.
- Load latency:
  - IDLE: 1 cycle.
  - RUN: up to D_old cycles (terminal count of the current period).
- `otick` and `oack` are coincident on a deferred load commit.

## Configuration
- `CLK_PRESCALER_PHASE_ALIGN_EN` defined: loads in RUN apply immediately, with no PEND state and `obusy` tied to 0.
  - At the capturing edge: `div_r`←D, `cnt`←D−1, `oack`=1 next cycle, and `otick`←0 even if the old `cnt` was 0.
  - The phase restarts at the load edge, so the first new tick comes D cycles after it.
- Undefined (default): deferred, glitch-free commit as described in Operation.

## Test plan
- Reset, then `ien`=1 at edge 0 with default D=2 → `otick` high after edges 2, 4, 6, …; `oack`=`obusy`=0 throughout.
- In IDLE, `idiv`=5 with `iload` for 1 cycle → `oack` one cycle later; then `ien`=1 → ticks every 5 cycles. Feeding the toggle stage gives an output period of 10 cycles.
- In RUN with D=4 and `cnt`=2, load D=3 (default build) → `obusy`=1; the tick at `cnt`==0 comes with `oack`; following ticks are 3 cycles apart.
- In PEND, load 7 then 9 → exactly one `oack`, and the post-commit period is 9.
- `idiv`=0 loaded → behaves as D=1 (`otick` continuously high); dropping `ien` on a terminal-count edge → no tick; `irst_n`=0 mid-PEND → `div_r`=RESET_DIV, no `oack`.
- With `CLK_PRESCALER_PHASE_ALIGN_EN`, load D=6 in RUN at edge m → `oack` after m+1, next `otick` after m+6, `obusy` never 1.

Source files
------------

// File: rtl/clk_prescaler.sv
// clk_prescaler: programmable prescaler that emits a one-cycle otick every D
// cycles of iclk. A new divisor is loaded via iload/oack. By default a load
// made while running is deferred to the end of the current period, so no
// glitched tick is produced.
// Optional macro CLK_PRESCALER_PHASE_ALIGN_EN: loads made while running take
// effect immediately and restart the phase; the PEND state is never entered
// and obusy stays 0.

module clk_prescaler #(
    parameter int unsigned W         = 16,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         ien,
    input  logic [W-1:0] idiv,
    input  logic         iload,
    output logic         oack,
    output logic         otick,
    output logic         obusy
);

    localparam logic [W-1:0] RST_DIV = W'(RESET_DIV);
    localparam logic [W-1:0] RST_CNT = W'(RESET_DIV - 1);
    localparam logic [W-1:0] ONE     = W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_div;
    logic [W-1:0] r_pend;
    logic [W-1:0] r_cnt;

    logic [W-1:0] w_d;
    logic [W-1:0] w_d_m1;
    logic [W-1:0] w_div_m1;
    logic [W-1:0] w_pend_m1;
    logic         w_cnt_zero;

    // Requested divisor with 0 promoted to 1, plus reload values
    assign w_d        = (idiv == '0) ? ONE : idiv;
    assign w_d_m1     = w_d - ONE;
    assign w_div_m1   = r_div - ONE;
    assign w_pend_m1  = r_pend - ONE;
    assign w_cnt_zero = (r_cnt == '0);

`ifndef CLK_PRESCALER_PHASE_ALIGN_EN
    logic [W-1:0] w_commit;
    logic [W-1:0] w_commit_m1;

    // Value committed at the terminal count in PEND; a same-edge load wins
    assign w_commit    = iload ? w_d : r_pend;
    assign w_commit_m1 = w_commit - ONE;
`endif

    // Control FSM with counter, divisor registers and registered outputs
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_state <= S_IDLE;
            r_div   <= RST_DIV;
            r_cnt   <= RST_CNT;
            r_pend  <= '0;
            otick   <= 1'b0;
            oack    <= 1'b0;
            obusy   <= 1'b0;
        end else begin
            otick <= 1'b0;
            oack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    obusy <= 1'b0;
                    r_cnt <= w_div_m1;
                    if (iload) begin
                        r_div <= w_d;
                        r_cnt <= w_d_m1;
                        oack  <= 1'b1;
                    end
                    if (ien) begin
                        r_state <= S_RUN;
                    end
                end

                S_RUN, S_PEND: begin
                    if (!ien) begin
                        // Stop: no tick on this edge, any pending value is committed
                        r_state <= S_IDLE;
                        obusy   <= 1'b0;
                        if (iload) begin
                            r_div <= w_d;
                            r_cnt <= w_d_m1;
                            oack  <= 1'b1;
                        end else if (r_state == S_PEND) begin
                            r_div <= r_pend;
                            r_cnt <= w_pend_m1;
                            oack  <= 1'b1;
                        end else begin
                            r_cnt <= w_div_m1;
                        end
                    end else begin
`ifdef CLK_PRESCALER_PHASE_ALIGN_EN
                        obusy   <= 1'b0;
                        r_state <= S_RUN;
                        if (iload) begin
                            // Immediate apply: phase restarts at this edge
                            r_div <= w_d;
                            r_cnt <= w_d_m1;
                            oack  <= 1'b1;
                        end else if (w_cnt_zero) begin
                            otick <= 1'b1;
                            r_cnt <= w_div_m1;
                        end else begin
                            r_cnt <= r_cnt - ONE;
                        end
`else
                        if (w_cnt_zero) begin
                            otick <= 1'b1;
                            if (r_state == S_PEND) begin
                                // Old period ends here; new divisor starts now
                                r_div   <= w_commit;
                                r_cnt   <= w_commit_m1;
                                oack    <= 1'b1;
                                r_state <= S_RUN;
                                obusy   <= 1'b0;
                            end else begin
                                r_cnt <= w_div_m1;
                                if (iload) begin
                                    r_pend  <= w_d;
                                    r_state <= S_PEND;
                                    obusy   <= 1'b1;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt - ONE;
                            if (iload) begin
                                r_pend  <= w_d;
                                r_state <= S_PEND;
                                obusy   <= 1'b1;
                            end
                        end
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= w_div_m1;
                    obusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_prescaler.sv
// Self-checking bench for clk_prescaler: directed scenarios plus a randomized
// run, all compared against a period/elapsed-cycle reference model.

module tb_clk_prescaler;

    localparam int unsigned W       = 16;
    localparam int unsigned RST_DIV = 2;

    logic         iclk = 1'b0;
    logic         irst_n;
    logic         ien;
    logic [W-1:0] idiv;
    logic         iload;
    logic         oack;
    logic         otick;
    logic         obusy;

    int n_tests = 0;
    int n_fail  = 0;

    clk_prescaler #(.W(W), .RESET_DIV(RST_DIV)) dut (
        .iclk  (iclk),
        .irst_n(irst_n),
        .ien   (ien),
        .idiv  (idiv),
        .iload (iload),
        .oack  (oack),
        .otick (otick),
        .obusy (obusy)
    );

    always #5 iclk = ~iclk;

    // Reference model: active period, edges elapsed in the current period,
    // and an optional pending divisor.
    bit m_run  = 0;
    bit m_pend = 0;
    int m_div  = RST_DIV;
    int m_pv   = 0;
    int m_el   = 0;
    int m_d;
    bit m_tick = 0;
    bit m_ack  = 0;
    bit m_busy = 0;

    always @(posedge iclk) begin
        m_d    = (idiv == 0) ? 1 : int'(idiv);
        m_tick = 0;
        m_ack  = 0;
        if (!irst_n) begin
            m_div  = RST_DIV;
            m_run  = 0;
            m_pend = 0;
            m_el   = 0;
        end else if (!m_run) begin
            if (iload) begin
                m_div = m_d;
                m_ack = 1;
            end
            if (ien) begin
                m_run = 1;
                m_el  = 0;
            end
        end else if (!ien) begin
            m_run = 0;
            if (iload) begin
                m_div = m_d;
                m_ack = 1;
            end else if (m_pend) begin
                m_div = m_pv;
                m_ack = 1;
            end
            m_pend = 0;
        end else begin
`ifdef CLK_PRESCALER_PHASE_ALIGN_EN
            if (iload) begin
                m_div = m_d;
                m_el  = 0;
                m_ack = 1;
            end else begin
                m_el = m_el + 1;
                if (m_el == m_div) begin
                    m_tick = 1;
                    m_el   = 0;
                end
            end
`else
            m_el = m_el + 1;
            if (m_el == m_div) begin
                m_tick = 1;
                m_el   = 0;
                if (m_pend) begin
                    m_div  = iload ? m_d : m_pv;
                    m_ack  = 1;
                    m_pend = 0;
                end else if (iload) begin
                    m_pend = 1;
                    m_pv   = m_d;
                end
            end else if (iload) begin
                m_pend = 1;
                m_pv   = m_d;
            end
`endif
        end
        m_busy = m_pend;
    end

    // Toggle stage fed by otick, as in the real clock chain
    logic r_tgl;
    always @(posedge iclk) begin
        if (!irst_n) r_tgl <= 1'b0;
        else if (otick) r_tgl <= ~r_tgl;
    end

    task automatic test_reset();
        irst_n = 1'b0; ien = 1'b1; iload = 1'b1; idiv = 16'd7;
        for (int i = 0; i < 3; i++) begin
            @(posedge iclk); #1;
            n_tests++;
            if ({otick, oack, obusy} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset cyc %0d: tick/ack/busy=%b required 000", i, {otick, oack, obusy});
            end
        end
        irst_n = 1'b1; ien = 1'b0; iload = 1'b0;
        @(posedge iclk); #1;
        n_tests++;
        if ({otick, oack, obusy} !== {m_tick, m_ack, m_busy}) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", {otick, oack, obusy}, {m_tick, m_ack, m_busy});
        end
    endtask

    task automatic test_default_div();
        ien = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(posedge iclk); #1;
            n_tests++;
            if ({otick, oack, obusy} !== {(j >= 2 && j % 2 == 0), 2'b00}) begin
                n_fail++;
                $display("FAIL default_div edge %0d: got %b expected %b", j, {otick, oack, obusy},
                         {(j >= 2 && j % 2 == 0), 2'b00});
            end
        end
        ien = 1'b0;
        @(posedge iclk); #1;
        n_tests++;
        if (otick !== 1'b0) begin
            n_fail++;
            $display("FAIL default_div_stop: otick=%b required 0", otick);
        end
    endtask

    task automatic test_idle_load();
        int last_tick = -1;
        int last_rise = -1;
        logic prev_tgl;
        idiv = 16'd5; iload = 1'b1;
        @(posedge iclk); #1;
        n_tests++;
        if (oack !== 1'b1 || otick !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_load_ack: ack=%b tick=%b required 1 0", oack, otick);
        end
        iload = 1'b0; ien = 1'b1;
        prev_tgl = r_tgl;
        for (int j = 0; j < 32; j++) begin
            @(posedge iclk); #1;
            n_tests++;
            if ({otick, oack, obusy} !== {m_tick, m_ack, m_busy}) begin
                n_fail++;
                $display("FAIL idle_load cyc %0d: got %b expected %b", j, {otick, oack, obusy}, {m_tick, m_ack, m_busy});
            end
            if (otick) begin
                if (last_tick >= 0) begin
                    n_tests++;
                    if (j - last_tick !== 5) begin
                        n_fail++;
                        $display("FAIL idle_load_spacing: %0d required 5", j - last_tick);
                    end
                end
                last_tick = j;
            end
            if (r_tgl && !prev_tgl) begin
                if (last_rise >= 0) begin
                    n_tests++;
                    if (j - last_rise !== 10) begin
                        n_fail++;
                        $display("FAIL toggle_period: %0d required 10", j - last_rise);
                    end
                end
                last_rise = j;
            end
            prev_tgl = r_tgl;
        end
        ien = 1'b0;
        @(posedge iclk); #1;
    endtask

    task automatic test_pend_load();
        idiv = 16'd4; iload = 1'b1;
        @(posedge iclk); #1;
        iload = 1'b0; ien = 1'b1;
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        idiv = 16'd3; iload = 1'b1;
        @(posedge iclk); #1;
        iload = 1'b0;
`ifndef CLK_PRESCALER_PHASE_ALIGN_EN
        n_tests++;
        if (obusy !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_busy: obusy=%b required 1", obusy);
        end
`endif
        for (int j = 0; j < 15; j++) begin
            @(posedge iclk); #1;
            n_tests++;
            if ({otick, oack, obusy} !== {m_tick, m_ack, m_busy}) begin
                n_fail++;
                $display("FAIL pend_load cyc %0d: got %b expected %b", j, {otick, oack, obusy}, {m_tick, m_ack, m_busy});
            end
`ifndef CLK_PRESCALER_PHASE_ALIGN_EN
            if (oack) begin
                n_tests++;
                if (otick !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pend_commit_tick: otick=%b required 1 with oack", otick);
                end
            end
`endif
        end
    endtask

    task automatic test_pend_overwrite();
        int acks = 0;
        ien = 1'b0;
        @(posedge iclk); #1;
        idiv = 16'd5; iload = 1'b1;
        @(posedge iclk); #1;
        iload = 1'b0; ien = 1'b1;
        @(posedge iclk); #1;
        idiv = 16'd7; iload = 1'b1;
        @(posedge iclk); #1;
        acks += int'(oack);
        idiv = 16'd9;
        @(posedge iclk); #1;
        acks += int'(oack);
        iload = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(posedge iclk); #1;
            acks += int'(oack);
            n_tests++;
            if ({otick, oack, obusy} !== {m_tick, m_ack, m_busy}) begin
                n_fail++;
                $display("FAIL pend_overwrite cyc %0d: got %b expected %b", j, {otick, oack, obusy}, {m_tick, m_ack, m_busy});
            end
        end
`ifndef CLK_PRESCALER_PHASE_ALIGN_EN
        n_tests++;
        if (acks !== 1) begin
            n_fail++;
            $display("FAIL pend_overwrite_acks: %0d required 1", acks);
        end
`endif
    endtask

    task automatic test_zero_div();
        ien = 1'b0;
        @(posedge iclk); #1;
        idiv = 16'd0; iload = 1'b1; ien = 1'b1;
        @(posedge iclk); #1;
        iload = 1'b0;
        n_tests++;
        if (oack !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_div_ack: oack=%b required 1", oack);
        end
        for (int j = 1; j < 8; j++) begin
            @(posedge iclk); #1;
            n_tests++;
            if (otick !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_div edge %0d: otick=%b required 1", j, otick);
            end
        end
        ien = 1'b0;
        @(posedge iclk); #1;
    endtask

    task automatic test_ien_drop();
        idiv = 16'd3; iload = 1'b1;
        @(posedge iclk); #1;
        iload = 1'b0; ien = 1'b1;
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        ien = 1'b0;
        @(posedge iclk); #1;
        n_tests++;
        if ({otick, oack, obusy} !== 3'b000 || m_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL ien_drop: got %b required 000", {otick, oack, obusy});
        end
    endtask

    task automatic test_reset_mid_pend();
        ien = 1'b1;
        @(posedge iclk); #1;
        idiv = 16'd8; iload = 1'b1;
        @(posedge iclk); #1;
        iload = 1'b0; irst_n = 1'b0;
        @(posedge iclk); #1;
        irst_n = 1'b1;
        n_tests++;
        if ({otick, oack, obusy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_pend: got %b required 000", {otick, oack, obusy});
        end
        for (int j = 0; j < 10; j++) begin
            @(posedge iclk); #1;
            n_tests++;
            if ({otick, oack, obusy} !== {(j >= 2 && j % 2 == 0), 2'b00}) begin
                n_fail++;
                $display("FAIL reset_mid_pend_div edge %0d: got %b expected %b", j, {otick, oack, obusy},
                         {(j >= 2 && j % 2 == 0), 2'b00});
            end
        end
    endtask

`ifdef CLK_PRESCALER_PHASE_ALIGN_EN
    task automatic test_phase_align();
        ien = 1'b1;
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        idiv = 16'd6; iload = 1'b1;
        @(posedge iclk); #1;
        iload = 1'b0;
        n_tests++;
        if (oack !== 1'b1 || otick !== 1'b0) begin
            n_fail++;
            $display("FAIL phase_align_ack: ack=%b tick=%b required 1 0", oack, otick);
        end
        for (int j = 1; j <= 6; j++) begin
            @(posedge iclk); #1;
            n_tests++;
            if ({otick, obusy} !== {(j == 6), 1'b0}) begin
                n_fail++;
                $display("FAIL phase_align edge m+%0d: tick/busy=%b required %b", j, {otick, obusy}, {(j == 6), 1'b0});
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int j = 0; j < 3000; j++) begin
            irst_n = ($urandom_range(0, 199) != 0);
            ien    = ($urandom_range(0, 15) != 0);
            iload  = ien && ($urandom_range(0, 9) == 0);
            idiv   = W'($urandom_range(0, 7));
            @(posedge iclk); #1;
            n_tests++;
            if ({otick, oack, obusy} !== {m_tick, m_ack, m_busy}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b expected %b", j, {otick, oack, obusy}, {m_tick, m_ack, m_busy});
            end
        end
        irst_n = 1'b1; ien = 1'b0; iload = 1'b0;
    endtask

    initial begin
        irst_n = 1'b0; ien = 1'b0; iload = 1'b0; idiv = '0;
        test_reset();
        test_default_div();
        test_idle_load();
        test_pend_load();
        test_pend_overwrite();
        test_zero_div();
        test_ien_drop();
        test_reset_mid_pend();
`ifdef CLK_PRESCALER_PHASE_ALIGN_EN
        test_phase_align();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
